// File: rtl/sar_search.sv
// Successive-approximation search driving an external comparator, MSB first.
// Optional SAR_EARLY_EXIT_EN: finish as soon as the comparator reports equality.
module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             agb,
  input  logic             alb,
  input  logic             aeqb,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, TRY, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] trial_nx, result_nx, decided;
  logic [IW-1:0]    idx, idx_nx;

  // Only alb steers the decision; agb (and aeqb without early exit) are not consulted.
`ifdef SAR_EARLY_EXIT_EN
  logic unused_inputs;
  assign unused_inputs = agb;
`else
  logic unused_inputs;
  assign unused_inputs = agb ^ aeqb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      state  <= state_nx;
      trial  <= trial_nx;
      idx    <= idx_nx;
      result <= result_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    trial_nx  = trial;
    idx_nx    = idx;
    result_nx = result;
    decided   = trial;
    busy      = 1'b0;
    done      = 1'b0;
    if (alb) decided[idx] = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx            = TRY;
          trial_nx            = '0;
          trial_nx[WIDTH-1]   = 1'b1;
          idx_nx              = IW'(WIDTH - 1);
        end
      end
      TRY: begin
        busy = 1'b1;
        if (abort) begin
          state_nx = IDLE;
          trial_nx = '0;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (aeqb) begin
          state_nx  = DONE;
          result_nx = trial;
          trial_nx  = '0;
        end
`endif
        else if (idx == '0) begin
          state_nx  = DONE;
          result_nx = decided;
          trial_nx  = '0;
        end else begin
          // Resolve bit idx and tentatively raise the next lower bit on the same edge.
          decided[idx - 1'b1] = 1'b1;
          trial_nx            = decided;
          idx_nx              = idx - 1'b1;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (WIDTH=4) with a behavioural comparator on trial.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       agb, alb, aeqb;
  logic [3:0] trial, result, target;
  logic       busy, done;
  int         n_chk = 0;
  int         n_fail = 0;

  sar_search #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .agb(agb), .alb(alb), .aeqb(aeqb),
    .trial(trial), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always_comb begin
    agb  = (target > trial);
    alb  = (target < trial);
    aeqb = (target == trial);
  end

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one search, optionally re-pulsing start on TRY cycle index repulse.
  task automatic do_search(input string tag, input logic [3:0] tgt, input int exp_busy,
                           input logic [3:0] exp_res, input int repulse);
    int nb;
    int nd;
    nb = 0;
    nd = 0;
    target = tgt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        break;
      end
      start = (c == repulse);
      step();
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_done_seen"}, nd, 1);
    chk({tag, "_result"}, {28'd0, result}, {28'd0, exp_res});
    chk({tag, "_trial_in_done"}, {28'd0, trial}, 32'd0);
    step();
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    step();
    chk({tag, "_no_restart"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nd;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    target = 4'd0;
    #12;
    chk("rst_trial",  {28'd0, trial},  32'd0);
    chk("rst_result", {28'd0, result}, 32'd0);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Abort while idle does nothing.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);

    // Trial sequence for target 1100.
    target = 4'b1100;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("seq_t0", {28'd0, trial}, 32'b1000);
    chk("seq_busy0", {31'd0, busy}, 32'd1);
    step();
    chk("seq_t1", {28'd0, trial}, 32'b1100);
    step();
    if (EE) begin
      chk("seq_ee_done", {31'd0, done}, 32'd1);
    end else begin
      chk("seq_t2", {28'd0, trial}, 32'b1110);
      step();
      chk("seq_t3", {28'd0, trial}, 32'b1101);
      step();
      chk("seq_done", {31'd0, done}, 32'd1);
    end
    chk("seq_result", {28'd0, result}, 32'b1100);
    step();
    chk("seq_done_drop", {31'd0, done}, 32'd0);

    do_search("t1100", 4'b1100, EE ? 2 : 4, 4'b1100, -1);
    do_search("t0000", 4'b0000, 4, 4'b0000, -1);
    do_search("t1111", 4'b1111, 4, 4'b1111, -1);
    do_search("t0100_repulse", 4'b0100, EE ? 2 : 4, 4'b0100, 1);

    // Abort on the third TRY cycle; abort wins even over equality.
    target = 4'b1010;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("abort_pre_trial", {28'd0, trial}, 32'b1010);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy",   {31'd0, busy},   32'd0);
    chk("abort_done",   {31'd0, done},   32'd0);
    chk("abort_trial",  {28'd0, trial},  32'd0);
    chk("abort_result", {28'd0, result}, 32'b0100);
    nd = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done || busy) nd++;
    end
    chk("abort_quiet", nd, 0);
    do_search("t1010", 4'b1010, EE ? 3 : 4, 4'b1010, -1);

    // Asynchronous reset on the second TRY cycle, between edges.
    target = 4'b0111;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rst_mid_trial", {28'd0, trial}, 32'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_trial",  {28'd0, trial},  32'd0);
    chk("amid_busy",   {31'd0, busy},   32'd0);
    chk("amid_done",   {31'd0, done},   32'd0);
    chk("amid_result", {28'd0, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done || busy) nd++;
    end
    chk("amid_no_done", nd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
